// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO peripheral: register offsets, TCON bit indices, decode helper.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGITS  = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  typedef enum logic [2:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_LED,
    REG_DIGITS,
    REG_SYSTICK,
    REG_NONE
  } reg_sel_e;

  // Maps a word offset from the window base onto a register slot.
  function automatic reg_sel_e decode_word(input logic [29:0] w);
    reg_sel_e r;
    r = REG_NONE;
    if (w == 30'(OFF_TH[7:2]))      r = REG_TH;
    if (w == 30'(OFF_TL[7:2]))      r = REG_TL;
    if (w == 30'(OFF_TCON[7:2]))    r = REG_TCON;
    if (w == 30'(OFF_LED[7:2]))     r = REG_LED;
    if (w == 30'(OFF_DIGITS[7:2]))  r = REG_DIGITS;
    if (w == 30'(OFF_SYSTICK[7:2])) r = REG_SYSTICK;
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Reloadable timer: TH/TL/TCON registers, prescaler, overflow reload and interrupt status.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wdata_i,
  input  logic        we_th_i,
  input  logic        we_tl_i,
  input  logic        we_tcon_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [15:0] psc_q, psc_d;
  logic        tick;
  logic        ovf;

  always_comb begin
    tick   = tcon_q[TCON_EN] && (psc_q == 16'(PRESCALE - 1));
    ovf    = tick && (tl_q == '1);
    psc_d  = (!tcon_q[TCON_EN] || tick) ? '0 : psc_q + 16'd1;
    th_d   = we_th_i ? wdata_i : th_q;

    // A CPU write to TL swallows any tick in the same cycle.
    tl_d = tl_q;
    if (we_tl_i)   tl_d = wdata_i;
    else if (ovf)  tl_d = th_q;
    else if (tick) tl_d = tl_q + 32'd1;

    tcon_d = tcon_q;
    if (ovf && tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
    if (we_tcon_i) begin
      tcon_d          = wdata_i[2:0];
      tcon_d[TCON_IS] = wdata_i[TCON_IS] | (ovf & tcon_q[TCON_IE]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      psc_q  <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      psc_q  <= psc_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/mmio_periph.sv
// MEM-stage MMIO responder: decode, LED/DIGITS registers, SYSTICK and read mux.
// Optional SYSTICK counter at 0x14 is built only when MMIO_SYSTICK_EN is defined.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        irq,
  output logic [15:0] led,
  output logic [3:0]  an,
  output logic [7:0]  bcd
);

  logic [29:0] word_off;
  reg_sel_e    sel;
  logic        we;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [15:0] led_q, led_d;
  logic [11:0] digits_q, digits_d;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign word_off = addr[31:2] - BASE_ADDR[31:2];

  always_comb begin
    sel = decode_word(word_off);
`ifndef MMIO_SYSTICK_EN
    if (sel == REG_SYSTICK) sel = REG_NONE;
`endif
  end

  assign hit = (sel != REG_NONE);
  assign we  = mem_write & hit;

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wdata_i   (wr_data),
    .we_th_i   (we && (sel == REG_TH)),
    .we_tl_i   (we && (sel == REG_TL)),
    .we_tcon_i (we && (sel == REG_TCON)),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irq)
  );

  always_comb begin
    led_d    = (we && (sel == REG_LED))    ? wr_data[15:0] : led_q;
    digits_d = (we && (sel == REG_DIGITS)) ? wr_data[11:0] : digits_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      digits_q <= '0;
    end else begin
      led_q    <= led_d;
      digits_q <= digits_d;
    end
  end

`ifdef MMIO_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_d;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_TH:      rd_mux = th;
      REG_TL:      rd_mux = tl;
      REG_TCON:    rd_mux = {29'd0, tcon};
      REG_LED:     rd_mux = {16'd0, led_q};
      REG_DIGITS:  rd_mux = {20'd0, digits_q};
`ifdef MMIO_SYSTICK_EN
      REG_SYSTICK: rd_mux = systick_q;
`endif
      default:     rd_mux = '0;
    endcase
  end

  assign rd_data = (mem_read && hit) ? rd_mux : '0;
  assign led     = led_q;
  assign an      = digits_q[11:8];
  assign bcd     = digits_q[7:0];

endmodule

// File: tb/tb_mmio_periph.sv
// Directed scoreboard bench for mmio_periph (PRESCALE=1 and PRESCALE=4 instances on one bus).
// SYSTICK checks follow MMIO_SYSTICK_EN.
module tb_mmio_periph;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;
  localparam logic [31:0] A_HOLE    = 32'h4000_0018;

  logic        clk, reset;
  logic [31:0] addr, wr_data;
  logic        mem_read, mem_write;
  logic [31:0] rd_data, rd_data4;
  logic        hit, hit4, irq, irq4;
  logic [15:0] led, led4;
  logic [3:0]  an, an4;
  logic [7:0]  bcd, bcd4;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] st_cnt;
  logic [31:0] st0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  mmio_periph #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data),
    .hit(hit), .irq(irq), .led(led), .an(an), .bcd(bcd)
  );

  mmio_periph #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data4),
    .hit(hit4), .irq(irq4), .led(led4), .an(an4), .bcd(bcd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running cycle count for SYSTICK.
  always @(posedge clk or posedge reset) begin
    if (reset) st_cnt <= '0;
    else       st_cnt <= st_cnt + 32'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_data = d; mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag, input bit on4 = 1'b0);
    sb_t e;
    addr = a; mem_read = 1'b1;
    e.tag = tag; e.val = exp;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk(e.tag, on4 ? rd_data4 : rd_data, e.val);
    mem_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wr_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk); @(negedge clk);

    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_led", {16'd0, led}, 32'd0);
    rd(A_TL, 32'd0, "rst_tl");
    rd(A_TCON, 32'd0, "rst_tcon");
    reset = 1'b0;

    // LED with simultaneous read: read sees pre-write value
    addr = A_LED; wr_data = 32'h0000_ABCD; mem_read = 1'b1; mem_write = 1'b1;
    begin
      sb_t e;
      e.tag = "rw_pre"; e.val = 32'd0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk(e.tag, rd_data, e.val);
    end
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
    chk("led_out", {16'd0, led}, 32'h0000_ABCD);
    rd(32'h4000_000E, 32'h0000_ABCD, "led_lowbits_ignored");

    wr(A_DIGITS, 32'h0000_07F1);
    chk("an_out", {28'd0, an}, 32'h7);
    chk("bcd_out", {24'd0, bcd}, 32'hF1);

    addr = A_HOLE; mem_read = 1'b1; #1;
    chk("hole_hit", {31'd0, hit}, 32'd0);
    chk("hole_rd", rd_data, 32'd0);
    mem_read = 1'b0;
    wr(A_HOLE, 32'hFFFF_FFFF);
    rd(A_LED, 32'h0000_ABCD, "hole_led_kept");
    rd(A_DIGITS, 32'h0000_07F1, "hole_digits_kept");
    rd(A_TH, 32'd0, "hole_th_kept");
    addr = A_TH; mem_read = 1'b0; #1;
    chk("rd_gated", rd_data, 32'd0);

    // Overflow and interrupt (PRESCALE=1)
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, 32'hFFFF_FFFE, "ovf_tl_start");
    @(negedge clk);
    rd(A_TL, 32'hFFFF_FFFF, "ovf_tl_max");
    chk("ovf_irq_low", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rd(A_TL, 32'hFFFF_FFF0, "ovf_tl_reload");
    rd(A_TCON, 32'd7, "ovf_tcon");
    chk("ovf_irq_high", {31'd0, irq}, 32'd1);
    wr(A_TCON, 32'd3);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(A_TCON, 32'd3, "tcon_cleared");

    // Collisions
    wr(A_TL, 32'h0000_0100);
    rd(A_TL, 32'h0000_0100, "tl_write_wins");
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    rd(A_TCON, 32'd7, "tcon_write_ovf");
    rd(A_TL, 32'hFFFF_FFF0, "tcon_write_ovf_tl");
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0055);
    rd(A_TL, 32'hFFFF_FFF0, "th_write_ovf_old_th");
    rd(A_TH, 32'h0000_0055, "th_write_ovf_th");
    chk("irq_before_reset", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-count
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_led", {16'd0, led}, 32'd0);
    chk("mid_rst_an", {28'd0, an}, 32'd0);
    chk("mid_rst_bcd", {24'd0, bcd}, 32'd0);
    rd(A_TH, 32'd0, "mid_rst_th");
    rd(A_TL, 32'd0, "mid_rst_tl");
    rd(A_TCON, 32'd0, "mid_rst_tcon");
    rd(A_DIGITS, 32'd0, "mid_rst_digits");
    @(negedge clk);
    reset = 1'b0;

    // Prescale
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'd1);
    repeat (4) @(negedge clk);
    rd(A_TL, 32'd1, "psc4_tl_1", 1'b1);
    rd(A_TL, 32'd4, "psc1_tl_4");
    repeat (16) @(negedge clk);
    rd(A_TL, 32'd5, "psc4_tl_5", 1'b1);
    rd(A_TL, 32'd20, "psc1_tl_20");

`ifdef MMIO_SYSTICK_EN
    st0 = st_cnt;
    addr = A_SYSTICK; mem_read = 1'b1; #1;
    chk("systick_hit", {31'd0, hit}, 32'd1);
    mem_read = 1'b0;
    rd(A_SYSTICK, st0, "systick_a");
    repeat (10) @(negedge clk);
    rd(A_SYSTICK, st0 + 32'd10, "systick_b");
    wr(A_SYSTICK, 32'd0);
    rd(A_SYSTICK, st0 + 32'd11, "systick_store_ignored");
`else
    st0 = st_cnt;
    addr = A_SYSTICK; mem_read = 1'b1; #1;
    chk("systick_off_hit", {31'd0, hit}, 32'd0);
    chk("systick_off_rd", rd_data, 32'd0);
    mem_read = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
